// File: rtl/step_seq_pkg.sv
// Shared types and default constants for the step sequencer.
package step_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int MAX_WAIT_DEF        = 15;
    localparam int CNT_W_DEF           = 8;

    function automatic logic is_busy(state_e s);
        return (s != S_IDLE) && (s != S_HALT);
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Board/datapath signals of the step sequencer; slave is the sequencer side.
interface step_sequencer_if #(
    parameter int CNT_W = step_seq_pkg::CNT_W_DEF
);
    logic             executeButton;
    logic             runMode;
    logic             opIsLoad;
    logic             opIsStore;
    logic             opIsHalt;
    logic             memReady;
    logic             irLoad;
    logic             memRe;
    logic             memWe;
    logic             pcInc;
    logic             rfWe;
    logic             busy;
    logic             halted;
    logic             timeoutErr;
    logic [CNT_W-1:0] stepCount;

    modport master (
        output executeButton, runMode, opIsLoad, opIsStore, opIsHalt, memReady,
        input  irLoad, memRe, memWe, pcInc, rfWe, busy, halted, timeoutErr, stepCount
    );

    modport slave (
        input  executeButton, runMode, opIsLoad, opIsStore, opIsHalt, memReady,
        output irLoad, memRe, memWe, pcInc, rfWe, busy, halted, timeoutErr, stepCount
    );
endinterface

// File: rtl/step_sequencer_button_conditioner.sv
// Push-button to single-cycle step request: 2-flop sync, optional debouncer, rising edge.
// Debouncer is built only when STEP_SEQ_DEBOUNCE_EN is defined.
module button_conditioner
    import step_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic step_req_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;
    logic req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef STEP_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = stable_q;
`else
    // Debouncer compiled out; the parameter is accepted but has no effect.
    if (DEBOUNCE_CYCLES >= 0) begin : g_no_debounce
        assign level = sync2_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_q <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            level_prev_q <= level;
            req_q        <= level & ~level_prev_q;
        end
    end

    assign step_req_o = req_q;

endmodule

// File: rtl/step_sequencer.sv
// Instruction-phase sequencer: single-step or free-run through FETCH..WB with memory waits.
// Button debouncing is enabled by defining STEP_SEQ_DEBOUNCE_EN.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int MAX_WAIT        = MAX_WAIT_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    step_sequencer_if.slave  bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              timeout_q;
    logic              timeout_d;
    logic              is_load_q;
    logic              is_load_d;
    logic              step_req;
    logic              ir_load;
    logic              complete;
    logic              wait_limit;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (Clk),
        .rst       (Rst),
        .button_i  (bus.executeButton),
        .step_req_o(step_req)
    );

    // This cycle would be the MAX_WAIT-th one without memReady.
    assign wait_limit = (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        count_d   = count_q;
        timeout_d = timeout_q;
        is_load_d = is_load_q;
        ir_load   = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.runMode || step_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.memReady) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = bus.opIsHalt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                is_load_d = bus.opIsLoad;
                state_d   = (bus.opIsLoad || bus.opIsStore) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.memReady) begin
                    if (is_load_q) state_d = S_WB;
                    else           complete = 1'b1;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                complete = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            count_d = count_q + 1'b1;
            state_d = bus.runMode ? S_FETCH : S_IDLE;
        end
    end

    // Strobes decode from the registered state so Rst clears them at once.
    assign bus.irLoad     = ir_load;
    assign bus.memRe      = (state_q == S_FETCH) || ((state_q == S_MEM) && is_load_q);
    assign bus.memWe      = (state_q == S_MEM) && !is_load_q;
    assign bus.pcInc      = (state_q == S_EXEC);
    assign bus.rfWe       = (state_q == S_WB);
    assign bus.busy       = is_busy(state_q);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.timeoutErr = timeout_q;
    assign bus.stepCount  = count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized bench for step_sequencer with a per-instruction phase/latency reference model.
module tb_step_sequencer;
    import step_seq_pkg::*;

    localparam int D  = 4;
    localparam int MW = 15;
    localparam int CW = 8;
`ifdef STEP_SEQ_DEBOUNCE_EN
    localparam int REQ_LAT = D + 2;
`else
    localparam int REQ_LAT = 2;
`endif
    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;

    typedef struct {
        int kind;
        int fd;
        int md;
    } instr_t;

    logic Clk = 1'b0;
    logic Rst;

    step_sequencer_if #(.CNT_W(CW)) bus ();

    step_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .MAX_WAIT       (MW),
        .CNT_W          (CW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int          checks;
    int          failures;
    instr_t      plan[$];
    int          fetch_idx;
    int          comp_idx;
    int          req_cnt;
    int          exp_count;
    bit          mem_pending;
    logic [CW-1:0] last_cnt;
    int          w_cyc, w_ir, w_pc, w_rf, w_re, w_we;
    int          busy_seen;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: phase lengths of one instruction from the phase rules.
    function automatic int exp_cycles(input instr_t t);
        case (t.kind)
            K_LOAD:  return (t.fd + 1) + 1 + 1 + (t.md + 1) + 1;
            K_STORE: return (t.fd + 1) + 1 + 1 + (t.md + 1);
            K_HALT:  return (t.fd + 1) + 1;
            default: return (t.fd + 1) + 1 + 1 + 1;
        endcase
    endfunction

    function automatic int exp_re(input instr_t t);
        return (t.fd + 1) + ((t.kind == K_LOAD) ? t.md + 1 : 0);
    endfunction

    function automatic int exp_we(input instr_t t);
        return (t.kind == K_STORE) ? t.md + 1 : 0;
    endfunction

    function automatic int rnd_delay();
        if ($urandom_range(0, 9) < 7) return $urandom_range(0, 3);
        return $urandom_range(0, MW - 1);
    endfunction

    task automatic clear_window();
        w_cyc = 0; w_ir = 0; w_pc = 0; w_rf = 0; w_re = 0; w_we = 0;
    endtask

    task automatic close_window();
        instr_t t;
        t = '{K_ALU, 0, 0};
        if (comp_idx < plan.size()) t = plan[comp_idx];
        check("instr_cycles", w_cyc, exp_cycles(t));
        check("irload_cnt", w_ir, 1);
        check("pcinc_cnt", w_pc, 1);
        check("rfwe_cnt", w_rf, (t.kind == K_STORE) ? 0 : 1);
        check("memre_cycles", w_re, exp_re(t));
        check("memwe_cycles", w_we, exp_we(t));
        exp_count = (exp_count + 1) % (1 << CW);
        check("step_count", int'(bus.stepCount), exp_count);
        comp_idx++;
        clear_window();
    endtask

    // One clock: drive datapath/memory responses, then sample and account.
    task automatic cycle();
        instr_t cur;
        int     delay;
        int     k;
        int     strobes;
        bit     active;
        bit     valid;
        @(posedge Clk);
        #2;
        k     = fetch_idx - 1;
        valid = (k >= 0) && (k < plan.size());
        cur   = '{K_ALU, 0, 0};
        if (valid) cur = plan[k];
        bus.opIsLoad  = valid && (cur.kind == K_LOAD);
        bus.opIsStore = valid && (cur.kind == K_STORE);
        bus.opIsHalt  = valid && (cur.kind == K_HALT);
        if (mem_pending)                delay = cur.md;
        else if (fetch_idx < plan.size()) delay = plan[fetch_idx].fd;
        else                            delay = 0;
        active = bus.memRe || bus.memWe;
        bus.memReady = active ? (req_cnt >= delay) : 1'($urandom_range(0, 1));
        #2;
        if (bus.stepCount != last_cnt) begin
            close_window();
            last_cnt = bus.stepCount;
        end
        if (bus.busy) begin
            busy_seen++;
            w_cyc++;
            w_ir += int'(bus.irLoad);
            w_pc += int'(bus.pcInc);
            w_rf += int'(bus.rfWe);
            w_re += int'(bus.memRe);
            w_we += int'(bus.memWe);
        end
        strobes = int'(bus.memRe) + int'(bus.memWe) + int'(bus.rfWe) + int'(bus.pcInc);
        check("strobe_onehot", int'(strobes <= 1), 1);
        if (active && bus.memReady) begin
            req_cnt = 0;
            if (mem_pending) begin
                mem_pending = 1'b0;
            end else begin
                fetch_idx++;
                if (fetch_idx <= plan.size())
                    mem_pending = (plan[fetch_idx-1].kind == K_LOAD) ||
                                  (plan[fetch_idx-1].kind == K_STORE);
            end
        end else if (active) begin
            req_cnt++;
        end
    endtask

    task automatic clear_model();
        plan.delete();
        fetch_idx = 0; comp_idx = 0; req_cnt = 0; exp_count = 0;
        mem_pending = 1'b0; last_cnt = '0; busy_seen = 0;
        clear_window();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.runMode = 1'b0; bus.executeButton = 1'b0; bus.memReady = 1'b0;
        bus.opIsLoad = 1'b0; bus.opIsStore = 1'b0; bus.opIsHalt = 1'b0;
        repeat (2) @(posedge Clk);
        #4;
        Rst = 1'b0;
        clear_model();
    endtask

    task automatic press_and_measure();
        int busy_at;
        busy_at = -1;
        bus.executeButton = 1'b1;
        for (int i = 1; i <= 40 && busy_at < 0; i++) begin
            cycle();
            if (bus.busy) busy_at = i;
        end
        check("step_latency", busy_at, REQ_LAT + 2);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) cycle();
        check("idle_reached", int'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        int     budget;
        int     nreq;
        checks = 0;
        failures = 0;

        // Reset values
        Rst = 1'b1;
        bus.runMode = 1'b0; bus.executeButton = 1'b0; bus.memReady = 1'b0;
        bus.opIsLoad = 1'b0; bus.opIsStore = 1'b0; bus.opIsHalt = 1'b0;
        #3;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_timeout", int'(bus.timeoutErr), 0);
        check("rst_count", int'(bus.stepCount), 0);
        check("rst_strobes", int'({bus.irLoad, bus.memRe, bus.memWe, bus.pcInc, bus.rfWe}), 0);
        do_reset();

        // Single steps with random instructions
        repeat (5) cycle();
        check("idle_no_press", busy_seen, 0);
        plan.push_back('{K_ALU, 0, 0});
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                t.kind = $urandom_range(0, 2);
                t.fd   = rnd_delay();
                t.md   = rnd_delay();
                plan.push_back(t);
            end
            press_and_measure();
            repeat ((i == 0) ? 20 - (REQ_LAT + 2) : $urandom_range(10, 20)) cycle();
            bus.executeButton = 1'b0;
            wait_idle();
            repeat (2 * D + 8) cycle();
            check("ss_count", int'(bus.stepCount), i + 1);
            check("ss_idle", int'(bus.busy), 0);
        end

        // Release and re-press while busy: second request is discarded
        plan.push_back('{K_LOAD, MW - 1, MW - 1});
        press_and_measure();
        repeat (4) cycle();
        bus.executeButton = 1'b0;
        repeat (8) cycle();
        bus.executeButton = 1'b1;
        repeat (10) cycle();
        bus.executeButton = 1'b0;
        wait_idle();
        repeat (2 * D + 8) cycle();
        check("discard_count", int'(bus.stepCount), 6);

`ifdef STEP_SEQ_DEBOUNCE_EN
        // Bouncing button never settles long enough
        busy_seen = 0;
        for (int r = 0; r < 4; r++) begin
            bus.executeButton = 1'b1;
            repeat (2) cycle();
            bus.executeButton = 1'b0;
            repeat (2) cycle();
        end
        repeat (10) cycle();
        check("bounce_no_step", busy_seen, 0);
        check("bounce_count", int'(bus.stepCount), 6);
        plan.push_back('{K_ALU, 0, 0});
        press_and_measure();
        repeat (12) cycle();
        bus.executeButton = 1'b0;
        wait_idle();
        repeat (2 * D + 8) cycle();
        check("steady_count", int'(bus.stepCount), 7);
`endif

        // Free run: 256 instructions then a halt opcode
        do_reset();
        for (int i = 0; i < 256; i++) begin
            t.kind = (i == 0) ? K_LOAD : (i == 1) ? K_STORE : int'($urandom_range(0, 2));
            t.fd   = (i < 2) ? 0 : rnd_delay();
            t.md   = (i < 2) ? 3 : rnd_delay();
            plan.push_back(t);
        end
        plan[2].fd = MW - 1;
        plan[3] = '{K_LOAD, 0, MW - 1};
        plan.push_back('{K_HALT, rnd_delay(), 0});
        budget = 100;
        foreach (plan[i]) budget += exp_cycles(plan[i]);
        bus.runMode = 1'b1;
        for (int i = 0; i < budget && !bus.halted; i++) cycle();
        check("run_halted", int'(bus.halted), 1);
        check("run_done", comp_idx, 256);
        check("run_wrap", int'(bus.stepCount), 0);
        check("run_no_timeout", int'(bus.timeoutErr), 0);
        check("halt_cycles", w_cyc, exp_cycles(plan[256]));
        check("halt_no_pcinc", w_pc, 0);
        check("halt_no_rfwe", w_rf, 0);
        busy_seen = 0;
        bus.executeButton = 1'b1;
        repeat (15) cycle();
        bus.executeButton = 1'b0;
        repeat (15) cycle();
        check("halt_press_busy", busy_seen, 0);
        check("halt_press_halted", int'(bus.halted), 1);
        check("halt_press_count", int'(bus.stepCount), 0);

        // Memory timeout in FETCH, then in MEM of a store
        for (int where = 0; where < 2; where++) begin
            do_reset();
            plan.push_back((where == 0) ? '{K_ALU, 1000, 0} : '{K_STORE, 0, 1000});
            bus.runMode = 1'b1;
            nreq = 0;
            for (int i = 0; i < 80 && !bus.halted; i++) begin
                cycle();
                nreq += (where == 0) ? int'(bus.memRe) : int'(bus.memWe);
            end
            check("to_wait_cycles", nreq, MW);
            check("to_flag", int'(bus.timeoutErr), 1);
            check("to_halted", int'(bus.halted), 1);
            check("to_req_dropped", int'(bus.memRe || bus.memWe), 0);
            check("to_count", int'(bus.stepCount), 0);
        end

        // Asynchronous reset in the middle of a store
        do_reset();
        plan.push_back('{K_STORE, 1, 8});
        bus.runMode = 1'b1;
        for (int i = 0; i < 20 && !bus.memWe; i++) cycle();
        check("mid_store_we", int'(bus.memWe), 1);
        bus.runMode = 1'b0;
        #1;
        Rst = 1'b1;
        #1;
        check("async_we_drop", int'(bus.memWe), 0);
        check("async_busy_drop", int'(bus.busy), 0);
        repeat (2) @(posedge Clk);
        #4;
        Rst = 1'b0;
        clear_model();
        repeat (3) cycle();
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_count", int'(bus.stepCount), 0);
        check("post_rst_strobes",
              int'({bus.irLoad, bus.memRe, bus.memWe, bus.pcInc, bus.rfWe, bus.halted, bus.timeoutErr}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Control sequencer for the unpipelined processor. It turns the debug execute button into clean single-step requests, or free-runs when run mode is selected. It steps the datapath through fetch, decode, execute, memory and writeback phases, issuing one-cycle strobes and waiting on memory handshakes. It sits between the board inputs (button, switches) and the processor datapath, replacing ad-hoc per-phase enables.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized button level must differ from the stable level before it is accepted (1..255).
- MAX_WAIT, 15: maximum cycles spent waiting for memReady in FETCH or MEM before timeout (1..255).
- CNT_W, 8: width of stepCount.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- executeButton  in  1  raw push-button level; asynchronous to Clk.
- runMode  in  1  1 = free run, 0 = single step; sampled in IDLE and at the end of each instruction.
- opIsLoad, opIsStore, opIsHalt  in  1 each  decoder outputs; valid in DECODE and EXEC; load/store mutually exclusive.
- memReady  in  1  memory completion; sampled in FETCH and MEM.
- irLoad  out  1  load instruction register.
- memRe  out  1  memory read request.
- memWe  out  1  memory write request.
- pcInc  out  1  increment PC.
- rfWe  out  1  register-file write.
- busy  out  1  state is not IDLE or HALT.
- halted  out  1  state is HALT.
- timeoutErr  out  1  sticky memory-timeout flag.
- stepCount  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH when runMode=1, or on a stepReq pulse when runMode=0.
- FETCH: memRe=1. On memReady, irLoad=1 (Mealy, same cycle) and the state goes to DECODE.
- DECODE: one cycle. If opIsHalt, go to HALT; else go to EXEC.
- EXEC: one cycle, pcInc=1. If load or store, go to MEM; else go to WB.
- MEM: memRe=1 (load) or memWe=1 (store) is held until memReady. Then a load goes to WB; a store completes the instruction.
- WB: one cycle, rfWe=1; completes the instruction.
- Completion: stepCount increments (wraps at 2^CNT_W-1 -> 0). Next state is FETCH if runMode=1, else IDLE.
- Wait counter: clears on entry to FETCH or MEM and increments each cycle memReady=0. If it reaches MAX_WAIT with memReady still 0, set timeoutErr, drop requests and go to HALT. If memReady arrives in the same cycle as the limit, memReady wins.
- HALT: absorbing; exit only by Rst. stepReq is ignored there.
- A stepReq that arrives while busy=1 or in HALT is discarded, not queued.
- Only one of memRe/memWe/rfWe/pcInc is ever high in a cycle.

## Timing
- Reset values: state IDLE, every strobe 0, busy 0, halted 0, timeoutErr 0, stepCount 0, debounce stable level 0, counters 0.
- Rst assertion mid-instruction drops every strobe immediately (asynchronous). There are no partial writes after Rst is asserted.
- Button path: 2-flop synchronizer, then debouncer, then rising-edge detect. stepReq is a single-cycle pulse DEBOUNCE_CYCLES+2 cycles after the first Clk edge that samples the button high. Holding the button produces exactly one pulse.
- Minimum instruction latency (memReady tied high), with FETCH at cycle 0:
  - ALU: FETCH, DECODE, EXEC, WB = 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Each cycle of memReady=0 adds one cycle.
- State and wait-counter transitions are registered; strobes are decoded from state, except irLoad.

## Configuration
- STEP_SEQ_DEBOUNCE_EN defined: debouncer present as described.
- Without STEP_SEQ_DEBOUNCE_EN: DEBOUNCE_CYCLES is unused. The synchronized level feeds edge detect directly, giving stepReq 2 cycles after sampling, for simulation and fast-clock use.

## Structure
- Package step_seq_pkg holds the state enum and the default constants for DEBOUNCE_CYCLES, MAX_WAIT and CNT_W.
- Sub-module button_conditioner contains the synchronizer, the debouncer (under the macro) and the edge detect; its output is stepReq.
- The FSM, wait counter and stepCount live in step_sequencer.

## Test plan
- Reset mid-MEM store (Rst=1 while memWe=1) -> memWe falls without waiting for a clock; after release: IDLE, stepCount=0, all outputs 0.
- Single step, DEBOUNCE_CYCLES=4: button high for 20 cycles, ALU op, memReady=1 -> stepReq 6 cycles after the first sampling edge. Then irLoad, pcInc and rfWe each pulse once; stepCount=1; back in IDLE.
- Button bounce: pulses of 2 cycles high / 2 cycles low for 16 cycles -> no stepReq; then a steady press -> exactly one instruction.
- Run mode, alternating load/store with memReady delayed 3 cycles -> load 8 cycles, store 7 cycles; stepCount increments per instruction and wraps 255 -> 0 after 256 instructions.
- Timeout, MAX_WAIT=15: memReady held 0 in FETCH -> timeoutErr=1 and halted=1 after 15 wait cycles; memRe=0; later presses ignored.
- opIsHalt in DECODE -> HALT; no pcInc; stepCount unchanged. With the macro undefined, stepReq latency is 2 cycles.
